// File: rtl/wb_port_arb_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arb_if
//  Purpose  : Bundles the requester-side result bus and the write-back /
//             commit outputs of the write-back port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface wb_port_arb_if #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5
);
  // Requester result bus (flattened, requester i occupies slice i)
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [NUM_REQ*REG_AW-1:0] req_rd_i;
  logic [NUM_REQ-1:0]        req_rd_wen_i;
  logic [NUM_REQ*XLEN-1:0]   req_wdata_i;
  logic [NUM_REQ*XLEN-1:0]   req_pc_i;
  logic [NUM_REQ-1:0]        req_ebreak_i;

  // Regfile write port and commit/trace path
  logic                      wb_wen_o;
  logic [REG_AW-1:0]         wb_rd_o;
  logic [XLEN-1:0]           wb_wdata_o;
  logic                      commit_valid_o;
  logic [XLEN-1:0]           commit_pc_o;
  logic                      ebreak_o;
  logic                      halted_o;
  logic [63:0]               instret_o;

  // Arbiter side
  modport slave (
    input  req_valid_i, req_rd_i, req_rd_wen_i, req_wdata_i, req_pc_i, req_ebreak_i,
    output req_ready_o, wb_wen_o, wb_rd_o, wb_wdata_o, commit_valid_o,
           commit_pc_o, ebreak_o, halted_o, instret_o
  );

  // Producer / environment side
  modport master (
    output req_valid_i, req_rd_i, req_rd_wen_i, req_wdata_i, req_pc_i, req_ebreak_i,
    input  req_ready_o, wb_wen_o, wb_rd_o, wb_wdata_o, commit_valid_o,
           commit_pc_o, ebreak_o, halted_o, instret_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : wb_port_arb
//  Purpose  : Round-robin arbiter for the single regfile write port and the
//             commit path. Registers the winning result, counts retired
//             instructions and halts after an ebreak retires.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_port_arb #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5
) (
  input  wire logic      clk_i,
  input  wire logic      rst_i,
  wb_port_arb_if.slave   bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  logic               w_grant;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_idx;
  logic [NUM_REQ-1:0] w_ready;

  logic [REG_AW-1:0]  w_rd;
  logic               w_rd_wen;
  logic [XLEN-1:0]    w_wdata;
  logic [XLEN-1:0]    w_pc;
  logic               w_ebreak;

  logic               commit_valid_q;
  logic               wb_wen_q;
  logic [REG_AW-1:0]  wb_rd_q;
  logic [XLEN-1:0]    wb_wdata_q;
  logic [XLEN-1:0]    commit_pc_q;
  logic               ebreak_q;
  logic [63:0]        instret_q;

  // FSM state and round-robin pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_RUN;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Round-robin search from ptr_q, pointer advance and halt transition
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    w_grant = 1'b0;
    w_gidx  = '0;
    w_idx   = '0;
    if (state_q == ST_RUN) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
        if (!w_grant && bus.req_valid_i[w_idx]) begin
          w_grant = 1'b1;
          w_gidx  = w_idx;
        end
      end
    end
    if (w_grant) begin
      ptr_d = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
      if (w_ebreak) begin
        state_d = ST_HALTED;
      end
    end
  end

  // Winner's payload and one-hot accept back to the producers
  always_comb begin
    w_ready  = w_grant ? (NUM_REQ'(1) << w_gidx) : '0;
    w_rd     = bus.req_rd_i[w_gidx*REG_AW +: REG_AW];
    w_rd_wen = bus.req_rd_wen_i[w_gidx];
    w_wdata  = bus.req_wdata_i[w_gidx*XLEN +: XLEN];
    w_pc     = bus.req_pc_i[w_gidx*XLEN +: XLEN];
    w_ebreak = bus.req_ebreak_i[w_gidx];
  end

  // Output stage: strobes reload every edge, payload holds between grants
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      commit_valid_q <= 1'b0;
      wb_wen_q       <= 1'b0;
      wb_rd_q        <= '0;
      wb_wdata_q     <= '0;
      commit_pc_q    <= '0;
      ebreak_q       <= 1'b0;
      instret_q      <= '0;
    end else begin
      commit_valid_q <= w_grant;
      // x0 writes and non-writing instructions still retire, but never hit the regfile
      wb_wen_q       <= w_grant && w_rd_wen && (w_rd != '0);
      ebreak_q       <= w_grant && w_ebreak;
      if (w_grant) begin
        wb_rd_q     <= w_rd;
        wb_wdata_q  <= w_wdata;
        commit_pc_q <= w_pc;
        instret_q   <= instret_q + 64'd1;
      end
    end
  end

  assign bus.req_ready_o    = w_ready;
  assign bus.wb_wen_o       = wb_wen_q;
  assign bus.wb_rd_o        = wb_rd_q;
  assign bus.wb_wdata_o     = wb_wdata_q;
  assign bus.commit_valid_o = commit_valid_q;
  assign bus.commit_pc_o    = commit_pc_q;
  assign bus.ebreak_o       = ebreak_q;
  assign bus.halted_o       = (state_q == ST_HALTED);
  assign bus.instret_o      = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_port_arb
//  Purpose  : Self-checking bench for wb_port_arb with a behavioural model of
//             the arbitration order, output stage and halt behaviour.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arb;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int AW = 5;
  localparam int OW = 1 + 1 + AW + XL + XL + 1 + 1 + 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arb_if #(.NUM_REQ(N), .XLEN(XL), .REG_AW(AW)) bus ();

  wb_port_arb #(.NUM_REQ(N), .XLEN(XL), .REG_AW(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Producer-side stimulus
  logic [N-1:0]  tb_valid;
  logic [N-1:0]  tb_wen;
  logic [N-1:0]  tb_ebk;
  logic [AW-1:0] tb_rd    [N];
  logic [XL-1:0] tb_wdata [N];
  logic [XL-1:0] tb_pc    [N];

  assign bus.req_valid_i  = tb_valid;
  assign bus.req_rd_wen_i = tb_wen;
  assign bus.req_ebreak_i = tb_ebk;

  always_comb begin
    bus.req_rd_i    = '0;
    bus.req_wdata_i = '0;
    bus.req_pc_i    = '0;
    for (int i = 0; i < N; i++) begin
      bus.req_rd_i[i*AW +: AW]    = tb_rd[i];
      bus.req_wdata_i[i*XL +: XL] = tb_wdata[i];
      bus.req_pc_i[i*XL +: XL]    = tb_pc[i];
    end
  end

  // Reference model state
  int            m_ptr;
  bit            m_halted;
  logic [63:0]   m_instret;
  bit            m_cv, m_wen, m_ebk;
  logic [AW-1:0] m_rd;
  logic [XL-1:0] m_wdata, m_pc;
  int            last_g;

  int n_pass  = 0;
  int n_total = 0;

  function automatic int pick();
    if (m_halted) return -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (tb_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    int g;
    g = pick();
    return (g < 0) ? '0 : (N'(1) << g);
  endfunction

  function automatic logic [N-1:0] onehot(input int g);
    return N'(1) << g;
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.commit_valid_o, bus.wb_wen_o, bus.wb_rd_o, bus.wb_wdata_o,
            bus.commit_pc_o, bus.ebreak_o, bus.halted_o, bus.instret_o};
  endfunction

  function automatic logic [OW-1:0] exp_out();
    return {m_cv, m_wen, m_rd, m_wdata, m_pc, m_ebk, m_halted, m_instret};
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_halted = 0; m_instret = '0;
    m_cv = 0; m_wen = 0; m_ebk = 0; m_rd = '0; m_wdata = '0; m_pc = '0;
    last_g = -1;
  endtask

  task automatic clear_reqs();
    tb_valid = '0; tb_wen = '0; tb_ebk = '0;
    for (int i = 0; i < N; i++) begin
      tb_rd[i] = '0; tb_wdata[i] = '0; tb_pc[i] = '0;
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic wen,
                         input logic [XL-1:0] wdata, input logic [XL-1:0] pc, input logic ebk);
    tb_valid[i] = 1'b1; tb_rd[i] = rd; tb_wen[i] = wen;
    tb_wdata[i] = wdata; tb_pc[i] = pc; tb_ebk[i] = ebk;
  endtask

  task automatic set_rand_req(input int i);
    set_req(i, AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom(), $urandom(), 1'b0);
  endtask

  // Predict the effect of the coming edge, then step to just after it
  task automatic advance();
    int g;
    g = pick();
    last_g = g;
    m_cv = (g >= 0);
    m_wen = 0;
    m_ebk = 0;
    if (g >= 0) begin
      m_wen = tb_wen[g] && (tb_rd[g] != 0);
      m_ebk = tb_ebk[g];
      m_rd = tb_rd[g]; m_wdata = tb_wdata[g]; m_pc = tb_pc[g];
      m_instret = m_instret + 64'd1;
      m_ptr = (g + 1) % N;
      if (tb_ebk[g]) m_halted = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_reqs();
    model_reset();
    #1;
    n_total++;
    if (obs() !== exp_out()) $display("FAIL reset_outputs: got %h expected %h", obs(), exp_out());
    else n_pass++;
    n_total++;
    if (dut.ptr_q !== 2'd0) $display("FAIL reset_ptr: got %0d expected 0", dut.ptr_q);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    n_total++;
    if (obs() !== exp_out()) $display("FAIL reset_release: got %h expected %h", obs(), exp_out());
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    set_req(1, 5'd5, 1'b1, 32'hDEADBEEF, 32'h80000004, 1'b0);
    #2;
    n_total++;
    if (bus.req_ready_o !== 3'b010) $display("FAIL single_ready: got %b expected 010", bus.req_ready_o);
    else n_pass++;
    advance();
    tb_valid[1] = 1'b0;
    n_total++;
    if (obs() !== exp_out()) $display("FAIL single_commit: got %h expected %h", obs(), exp_out());
    else n_pass++;
    n_total++;
    if ({bus.wb_wen_o, bus.wb_rd_o, bus.wb_wdata_o, bus.commit_pc_o, bus.instret_o} !==
        {1'b1, 5'd5, 32'hDEADBEEF, 32'h80000004, 64'd1})
      $display("FAIL single_values: got wen=%b rd=%0d wdata=%h pc=%h instret=%0d expected 1/5/deadbeef/80000004/1",
               bus.wb_wen_o, bus.wb_rd_o, bus.wb_wdata_o, bus.commit_pc_o, bus.instret_o);
    else n_pass++;
    advance();
    n_total++;
    if (obs() !== exp_out()) $display("FAIL single_idle: got %h expected %h", obs(), exp_out());
    else n_pass++;
  endtask

  task automatic test_contention();
    int order [4] = '{0, 1, 2, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_rand_req(i);
    for (int c = 0; c < 4; c++) begin
      #2;
      n_total++;
      if (bus.req_ready_o !== onehot(order[c]))
        $display("FAIL contention_ready%0d: got %b expected %b", c, bus.req_ready_o, onehot(order[c]));
      else n_pass++;
      advance();
      n_total++;
      if (obs() !== exp_out()) $display("FAIL contention_out%0d: got %h expected %h", c, obs(), exp_out());
      else n_pass++;
      n_total++;
      if (int'(dut.ptr_q) !== (order[c] + 1) % N)
        $display("FAIL contention_ptr%0d: got %0d expected %0d", c, dut.ptr_q, (order[c] + 1) % N);
      else n_pass++;
      if (last_g >= 0) set_rand_req(last_g);
    end
  endtask

  task automatic test_x0_nowrite();
    logic [63:0] base;
    clear_reqs();
    base = m_instret;
    set_req(0, 5'd0, 1'b1, 32'h12345678, 32'h80000100, 1'b0);
    #2;
    advance();
    tb_valid[0] = 1'b0;
    n_total++;
    if ({bus.commit_valid_o, bus.wb_wen_o} !== 2'b10 || obs() !== exp_out())
      $display("FAIL x0_commit: got %h expected %h", obs(), exp_out());
    else n_pass++;
    set_req(2, 5'd9, 1'b0, 32'hCAFEF00D, 32'h80000104, 1'b0);
    #2;
    advance();
    tb_valid[2] = 1'b0;
    n_total++;
    if ({bus.commit_valid_o, bus.wb_wen_o} !== 2'b10 || obs() !== exp_out())
      $display("FAIL nowen_commit: got %h expected %h", obs(), exp_out());
    else n_pass++;
    n_total++;
    if (bus.instret_o !== base + 64'd2)
      $display("FAIL x0_instret: got %0d expected %0d", bus.instret_o, base + 64'd2);
    else n_pass++;
  endtask

  task automatic test_fairness();
    int order [8] = '{0, 0, 0, 1, 0, 1, 0, 1};
    do_reset();
    set_rand_req(0);
    for (int c = 0; c < 8; c++) begin
      if (c == 3) set_rand_req(1);
      #2;
      n_total++;
      if (bus.req_ready_o !== onehot(order[c]))
        $display("FAIL fair_ready%0d: got %b expected %b", c, bus.req_ready_o, onehot(order[c]));
      else n_pass++;
      advance();
      n_total++;
      if (obs() !== exp_out()) $display("FAIL fair_out%0d: got %h expected %h", c, obs(), exp_out());
      else n_pass++;
      if (last_g >= 0) set_rand_req(last_g);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++)
        if (!tb_valid[i] && $urandom_range(0, 2) != 0) set_rand_req(i);
      #2;
      n_total++;
      if (bus.req_ready_o !== exp_ready())
        $display("FAIL rand_ready%0d: got %b expected %b", c, bus.req_ready_o, exp_ready());
      else n_pass++;
      advance();
      n_total++;
      if (obs() !== exp_out()) $display("FAIL rand_out%0d: got %h expected %h", c, obs(), exp_out());
      else n_pass++;
      if (last_g >= 0) tb_valid[last_g] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 5'd3, 1'b1, 32'hA5A5A5A5, 32'h80000200, 1'b0);
    #2;
    advance();
    tb_valid[0] = 1'b0;
    n_total++;
    if (bus.wb_wen_o !== 1'b1 || obs() !== exp_out())
      $display("FAIL midrst_pre: got %h expected %h", obs(), exp_out());
    else n_pass++;
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_total++;
    if (obs() !== exp_out()) $display("FAIL midrst_async: got %h expected %h", obs(), exp_out());
    else n_pass++;
    n_total++;
    if (dut.ptr_q !== 2'd0) $display("FAIL midrst_ptr: got %0d expected 0", dut.ptr_q);
    else n_pass++;
    for (int i = 0; i < N; i++) set_rand_req(i);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    n_total++;
    if (bus.req_ready_o !== 3'b001) $display("FAIL midrst_first: got %b expected 001", bus.req_ready_o);
    else n_pass++;
    advance();
    n_total++;
    if (obs() !== exp_out()) $display("FAIL midrst_out: got %h expected %h", obs(), exp_out());
    else n_pass++;
  endtask

  task automatic test_ebreak();
    do_reset();
    set_rand_req(1);
    #2;
    advance();
    tb_valid[1] = 1'b0;
    set_req(0, 5'd4, 1'b1, 32'h11112222, 32'h80000020, 1'b0);
    set_req(2, 5'd6, 1'b1, 32'h33334444, 32'h80000010, 1'b1);
    #2;
    n_total++;
    if (bus.req_ready_o !== 3'b100) $display("FAIL ebreak_ready: got %b expected 100", bus.req_ready_o);
    else n_pass++;
    advance();
    tb_valid[2] = 1'b0;
    n_total++;
    if ({bus.commit_valid_o, bus.ebreak_o, bus.halted_o, bus.commit_pc_o} !== {3'b111, 32'h80000010} ||
        obs() !== exp_out())
      $display("FAIL ebreak_commit: got %h expected %h", obs(), exp_out());
    else n_pass++;
    n_total++;
    if (bus.req_ready_o !== 3'b000) $display("FAIL ebreak_noready: got %b expected 000", bus.req_ready_o);
    else n_pass++;
    for (int c = 0; c < 11; c++) begin
      advance();
      n_total++;
      if ({bus.commit_valid_o, bus.ebreak_o, bus.wb_wen_o, bus.halted_o, bus.req_ready_o} !== 7'b0001000 ||
          obs() !== exp_out())
        $display("FAIL halted_quiet%0d: got %h ready=%b expected %h ready=000", c, obs(), bus.req_ready_o, exp_out());
      else n_pass++;
    end
  endtask

  initial begin
    clear_reqs();
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_contention();
    test_x0_nowrite();
    test_fairness();
    test_random();
    test_reset_mid();
    test_ebreak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
